// File: rtl/vccarb_pkg.sv
// Shared constants and types for the VCC write arbiter.
package vccarb_pkg;

   localparam int VCCARB_NUM_REQ = 8;
   localparam int VCCARB_WFID_W  = 6;
   localparam int VCCARB_VCC_W   = 64;
   localparam int VCCARB_CNT_W   = 3;

   localparam logic [2:0] SRC_SIMD0 = 3'd0;
   localparam logic [2:0] SRC_SIMD1 = 3'd1;
   localparam logic [2:0] SRC_SIMD2 = 3'd2;
   localparam logic [2:0] SRC_SIMD3 = 3'd3;
   localparam logic [2:0] SRC_SIMF0 = 3'd4;
   localparam logic [2:0] SRC_SIMF1 = 3'd5;
   localparam logic [2:0] SRC_SIMF2 = 3'd6;
   localparam logic [2:0] SRC_SIMF3 = 3'd7;

   typedef struct packed {
      logic [VCCARB_WFID_W-1:0] wfid;
      logic [VCCARB_VCC_W-1:0]  value;
   } vcc_entry_t;

endpackage

// File: rtl/vccarb_fifo.sv
// Per-requester FIFO of {wfid, value}; DEPTH must be 2 or 4 so the pointers wrap naturally.
module vccarb_fifo
   import vccarb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  vcc_entry_t              push_data,
   input  logic                    pop,
   output vcc_entry_t              head,
   output logic [VCCARB_CNT_W-1:0] count,
   output logic                    full,
   output logic                    empty
);

   localparam int PTR_W = $clog2(DEPTH);

   vcc_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == VCCARB_CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage is data only and is never reset; count/pointers qualify it.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + VCCARB_CNT_W'(push_ok) - VCCARB_CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/vcc_wr_arbiter.sv
// Buffered round-robin merge of eight VALU VCC write requests onto one exec write port.
// Optional SALU same-wfid hazard hold: define VCCARB_SALU_HAZARD_HOLD_EN.
module vcc_wr_arbiter
   import vccarb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   valu_vcc_wr_en,
   input  logic [47:0]  valu_vcc_wr_wfid,
   input  logic [511:0] valu_vcc_wr_value,
   output logic [7:0]   valu_vcc_wr_ready,
   input  logic         salu_wr_vcc_en,
   input  logic [5:0]   salu_wr_wfid,
   output logic         exec_vcc_wr_en,
   output logic [5:0]   exec_vcc_wr_wfid,
   output logic [63:0]  exec_vcc_wr_value,
   output logic [2:0]   exec_vcc_wr_src,
   output logic         issue_valu_wr_vcc_en,
   output logic [5:0]   issue_valu_wr_vcc_wfid,
   output logic         vccarb_overflow
);

   vcc_entry_t              head  [VCCARB_NUM_REQ];
   logic [VCCARB_CNT_W-1:0] count [VCCARB_NUM_REQ];
   logic [7:0]              full;
   logic [7:0]              empty;
   logic [7:0]              push;
   logic [7:0]              pop;
   logic [7:0]              hazard;
   logic [7:0]              elig;

   logic [2:0]              rr_ptr;
   logic [2:0]              grant;
   logic                    grant_vld;
   logic [2:0]              idx;

   logic                    vld_p1;
   logic [5:0]              wfid_p1;
   logic [63:0]             value_p1;
   logic [2:0]              src_p1;

   for (genvar i = 0; i < VCCARB_NUM_REQ; i++) begin : g_req
      vcc_entry_t din;

      // Ready looks only at the registered count, so a same-cycle pop never raises it.
      assign valu_vcc_wr_ready[i] = (count[i] < VCCARB_CNT_W'(DEPTH));
      assign push[i]              = valu_vcc_wr_en[i] && valu_vcc_wr_ready[i];
      assign pop[i]               = grant_vld && (grant == 3'(i));
      assign din.wfid             = valu_vcc_wr_wfid[6*i +: 6];
      assign din.value            = valu_vcc_wr_value[64*i +: 64];

      vccarb_fifo #(
         .DEPTH(DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[i]),
         .push_data (din),
         .pop       (pop[i]),
         .head      (head[i]),
         .count     (count[i]),
         .full      (full[i]),
         .empty     (empty[i])
      );

`ifdef VCCARB_SALU_HAZARD_HOLD_EN
      assign hazard[i] = salu_wr_vcc_en && (head[i].wfid == salu_wr_wfid);
`else
      assign hazard[i] = 1'b0;
`endif
   end

`ifndef VCCARB_SALU_HAZARD_HOLD_EN
   logic unused_salu;
   assign unused_salu = ^{salu_wr_vcc_en, salu_wr_wfid};
`endif

   assign elig = ~empty & ~hazard;

   // First eligible unit at or after rr_ptr, wrapping 7 -> 0.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = 0; k < VCCARB_NUM_REQ; k++) begin
         idx = rr_ptr + 3'(k);
         if (!grant_vld && elig[idx]) begin
            grant     = idx;
            grant_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (grant_vld) begin
         rr_ptr <= grant + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vccarb_overflow <= 1'b0;
      end else if (|(valu_vcc_wr_en & full)) begin
         vccarb_overflow <= 1'b1;
      end
   end

   // Stage p1: registered write port; payload holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         wfid_p1  <= '0;
         value_p1 <= '0;
         src_p1   <= '0;
      end else begin
         vld_p1 <= grant_vld;
         if (grant_vld) begin
            wfid_p1  <= head[grant].wfid;
            value_p1 <= head[grant].value;
            src_p1   <= grant;
         end
      end
   end

   assign exec_vcc_wr_en         = vld_p1;
   assign exec_vcc_wr_wfid       = wfid_p1;
   assign exec_vcc_wr_value      = value_p1;
   assign exec_vcc_wr_src        = src_p1;
   assign issue_valu_wr_vcc_en   = vld_p1;
   assign issue_valu_wr_vcc_wfid = wfid_p1;

endmodule

// File: tb/tb_vcc_wr_arbiter.sv
// Bench for vcc_wr_arbiter: directed vector table, hand sequences and random traffic vs a queue model.
module tb_vcc_wr_arbiter;

   localparam int DEPTH = 2;
`ifdef VCCARB_SALU_HAZARD_HOLD_EN
   localparam bit HAZ = 1'b1;
`else
   localparam bit HAZ = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   en;
   logic [47:0]  wfid_bus;
   logic [511:0] value_bus;
   logic [7:0]   ready;
   logic         salu_en;
   logic [5:0]   salu_wfid;
   logic         x_en;
   logic [5:0]   x_wfid;
   logic [63:0]  x_value;
   logic [2:0]   x_src;
   logic         i_en;
   logic [5:0]   i_wfid;
   logic         ovf;

   always #5 clk = ~clk;

   vcc_wr_arbiter #(.DEPTH(DEPTH)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .valu_vcc_wr_en         (en),
      .valu_vcc_wr_wfid       (wfid_bus),
      .valu_vcc_wr_value      (value_bus),
      .valu_vcc_wr_ready      (ready),
      .salu_wr_vcc_en         (salu_en),
      .salu_wr_wfid           (salu_wfid),
      .exec_vcc_wr_en         (x_en),
      .exec_vcc_wr_wfid       (x_wfid),
      .exec_vcc_wr_value      (x_value),
      .exec_vcc_wr_src        (x_src),
      .issue_valu_wr_vcc_en   (i_en),
      .issue_valu_wr_vcc_wfid (i_wfid),
      .vccarb_overflow        (ovf)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Behavioural model: one queue per unit and a round-robin pointer.
   typedef struct {
      logic [5:0]  w;
      logic [63:0] v;
   } ent_t;
   ent_t        q [8][$];
   int          m_rr;
   logic        m_en;
   logic [5:0]  m_wfid;
   logic [63:0] m_val;
   logic [2:0]  m_src;
   logic        m_ovf;

   function automatic logic [7:0] m_ready();
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = (q[i].size() < DEPTH);
      return r;
   endfunction

   task automatic model_step();
      int   pre [8];
      int   g;
      ent_t e;
      if (rst) begin
         for (int i = 0; i < 8; i++) q[i].delete();
         m_rr = 0; m_en = 0; m_wfid = 0; m_val = 0; m_src = 0; m_ovf = 0;
         return;
      end
      for (int i = 0; i < 8; i++) pre[i] = q[i].size();
      g = -1;
      for (int k = 0; k < 8; k++) begin
         int u;
         u = (m_rr + k) % 8;
         if (g < 0 && pre[u] > 0 &&
             !(HAZ && salu_en && q[u][0].w == salu_wfid)) g = u;
      end
      if (g >= 0) begin
         e = q[g].pop_front();
         m_en = 1; m_wfid = e.w; m_val = e.v; m_src = 3'(g);
         m_rr = (g + 1) % 8;
      end else begin
         m_en = 0;
      end
      for (int i = 0; i < 8; i++) begin
         if (en[i]) begin
            if (pre[i] < DEPTH) begin
               e.w = wfid_bus[6*i +: 6];
               e.v = value_bus[64*i +: 64];
               q[i].push_back(e);
            end else begin
               m_ovf = 1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   // Drive one cycle, advance model at the edge, compare #1 after it.
   task automatic step(input logic r, input logic [7:0] e, input logic [47:0] w,
                       input logic [511:0] v, input logic se, input logic [5:0] sw);
      rst = r; en = e; wfid_bus = w; value_bus = v; salu_en = se; salu_wfid = sw;
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      chk("exec_en", 64'(x_en), 64'(m_en));
      chk("exec_wfid", 64'(x_wfid), 64'(m_wfid));
      chk("exec_value", x_value, m_val);
      chk("exec_src", 64'(x_src), 64'(m_src));
      chk("issue_en", 64'(i_en), 64'(m_en));
      chk("issue_wfid", 64'(i_wfid), 64'(m_wfid));
      chk("ready", 64'(ready), 64'(m_ready()));
      chk("overflow", 64'(ovf), 64'(m_ovf));
   endtask

   task automatic build(input logic [5:0] wb, input logic [63:0] vb,
                        output logic [47:0] w, output logic [511:0] v);
      for (int i = 0; i < 8; i++) begin
         w[6*i +: 6]   = wb + 6'(i);
         v[64*i +: 64] = vb + 64'(i);
      end
   endtask

   typedef struct {
      logic        r;
      logic [7:0]  e;
      logic [5:0]  wb;
      logic [63:0] vb;
      logic        xen;
      logic [2:0]  xsrc;
      logic [5:0]  xwfid;
      logic [63:0] xval;
      logic [7:0]  xrdy;
      logic        xovf;
   } vec_t;

   vec_t tbl [25];

   initial begin
      logic [47:0]  w;
      logic [511:0] v;
      int           src2_edge;

      rst = 1; en = 0; wfid_bus = 0; value_bus = 0; salu_en = 0; salu_wfid = 0;
      m_rr = 0; m_en = 0; m_wfid = 0; m_val = 0; m_src = 0; m_ovf = 0;

      // Single request, reset, all-8 sweep, 0/7 alternation with overflow, reset.
      tbl[0]  = '{1'b1, 8'h00, 6'h00, 64'h000, 1'b0, 3'd0, 6'h00, 64'h000, 8'hFF, 1'b0};
      tbl[1]  = '{1'b0, 8'h02, 6'h01, 64'h004, 1'b0, 3'd0, 6'h00, 64'h000, 8'hFF, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 6'h01, 64'h004, 1'b1, 3'd1, 6'h02, 64'h005, 8'hFF, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 6'h01, 64'h004, 1'b0, 3'd1, 6'h02, 64'h005, 8'hFF, 1'b0};
      tbl[4]  = '{1'b1, 8'h00, 6'h00, 64'h000, 1'b0, 3'd0, 6'h00, 64'h000, 8'hFF, 1'b0};
      tbl[5]  = '{1'b0, 8'hFF, 6'h00, 64'h100, 1'b0, 3'd0, 6'h00, 64'h000, 8'hFF, 1'b0};
      for (int i = 0; i < 8; i++)
         tbl[6+i] = '{1'b0, 8'h00, 6'h00, 64'h100, 1'b1, 3'(i), 6'(i), 64'h100 + 64'(i), 8'hFF, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 6'h00, 64'h100, 1'b0, 3'd7, 6'h07, 64'h107, 8'hFF, 1'b0};
      tbl[15] = '{1'b0, 8'h81, 6'h10, 64'h200, 1'b0, 3'd7, 6'h07, 64'h107, 8'hFF, 1'b0};
      tbl[16] = '{1'b0, 8'h81, 6'h10, 64'h200, 1'b1, 3'd0, 6'h10, 64'h200, 8'h7F, 1'b0};
      tbl[17] = '{1'b0, 8'h81, 6'h10, 64'h200, 1'b1, 3'd7, 6'h17, 64'h207, 8'hFE, 1'b1};
      tbl[18] = '{1'b0, 8'h81, 6'h10, 64'h200, 1'b1, 3'd0, 6'h10, 64'h200, 8'h7F, 1'b1};
      tbl[19] = '{1'b0, 8'h81, 6'h10, 64'h200, 1'b1, 3'd7, 6'h17, 64'h207, 8'hFE, 1'b1};
      tbl[20] = '{1'b0, 8'h00, 6'h10, 64'h200, 1'b1, 3'd0, 6'h10, 64'h200, 8'hFF, 1'b1};
      tbl[21] = '{1'b0, 8'h00, 6'h10, 64'h200, 1'b1, 3'd7, 6'h17, 64'h207, 8'hFF, 1'b1};
      tbl[22] = '{1'b0, 8'h00, 6'h10, 64'h200, 1'b1, 3'd0, 6'h10, 64'h200, 8'hFF, 1'b1};
      tbl[23] = '{1'b0, 8'h00, 6'h10, 64'h200, 1'b0, 3'd0, 6'h10, 64'h200, 8'hFF, 1'b1};
      tbl[24] = '{1'b1, 8'h00, 6'h00, 64'h000, 1'b0, 3'd0, 6'h00, 64'h000, 8'hFF, 1'b0};

      for (int n = 0; n < 25; n++) begin
         build(tbl[n].wb, tbl[n].vb, w, v);
         step(tbl[n].r, tbl[n].e, w, v, 1'b0, 6'h00);
         chk("tbl_en", 64'(x_en), 64'(tbl[n].xen));
         chk("tbl_src", 64'(x_src), 64'(tbl[n].xsrc));
         chk("tbl_wfid", 64'(x_wfid), 64'(tbl[n].xwfid));
         chk("tbl_value", x_value, tbl[n].xval);
         chk("tbl_ready", 64'(ready), 64'(tbl[n].xrdy));
         chk("tbl_ovf", 64'(ovf), 64'(tbl[n].xovf));
      end

      // Hazard: simd2 wfid 5 against SALU wfid 5 for three edges, simd3 wfid 9 alongside.
      step(1'b1, 8'h00, 48'h0, 512'h0, 1'b0, 6'h0);
      w = '0; v = '0;
      w[12 +: 6] = 6'd5;  v[128 +: 64] = 64'hAAAA;
      w[18 +: 6] = 6'd9;  v[192 +: 64] = 64'hBBBB;
      src2_edge = -1;
      for (int k = 0; k < 7; k++) begin
         step(1'b0, (k == 0) ? 8'h0C : 8'h00, w, v, (k < 3), 6'd5);
         if (x_en && x_src == 3'd2 && src2_edge < 0) src2_edge = k + 1;
      end
      chk("hazard_grant_edge", 64'(src2_edge), HAZ ? 64'd4 : 64'd2);

      // Reset with four entries buffered.
      build(6'h20, 64'h300, w, v);
      step(1'b0, 8'h0F, w, v, 1'b0, 6'h0);
      step(1'b1, 8'h00, w, v, 1'b0, 6'h0);
      chk("rst_flush_ready", 64'(ready), 64'hFF);
      chk("rst_flush_ovf", 64'(ovf), 64'h0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 8'h00, w, v, 1'b0, 6'h0);
         chk("rst_flush_en", 64'(x_en), 64'h0);
      end

      // Random traffic with small wfid range so SALU collisions happen.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 8; i++) begin
            w[6*i +: 6]   = 6'($urandom_range(0, 3));
            v[64*i +: 64] = {$urandom, $urandom};
         end
         step(($urandom_range(0, 99) == 0), 8'($urandom),
              w, v, 1'($urandom), 6'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
